// File: rtl/common.sv
// Shared SystemBus definitions: fetch and the memory provider agree on one base address.
package common;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } MemState;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/sysbus_sram_array.sv
// Synchronous single-port word array with per-byte write enables and registered read data.
module sysbus_sram_array #(
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // rdata only moves on a read access, so it stays put while a response is held
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sysbus_mem.sv
// SystemBus memory provider: one outstanding request, fixed access latency, held response.
module sysbus_mem
    import common::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_PC,
    parameter int          DEPTH_WORDS = 16384,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    // 33 bits so a window reaching the top of the address space cannot overflow
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    MemState        state, state_next;
    logic [3:0]     cnt;
    logic [AW-1:0]  idx_q;
    logic           we_q, err_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic [31:0]    off;
    logic           req_err, accept, access;
    logic [31:0]    sram_rdata;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range
    assign off     = req_addr - BASE_ADDR;
    assign req_err = (req_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
    assign accept  = req_valid && req_ready;
    assign access  = (state == BUSY) && (cnt == 4'd0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            if (accept)                          cnt <= 4'(LATENCY - 1);
            else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= off[AW+1:2];
            we_q    <= req_we;
            err_q   <= req_err;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_rdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = BUSY;
            end
            BUSY: begin
                if (cnt == 4'd0) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                if (!we_q && !err_q) resp_rdata = sram_rdata;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    sysbus_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (access && !err_q),
        .we    (we_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_sysbus_mem.sv
// Directed bench for sysbus_mem with a transaction-level memory model checked every cycle.
module tb_sysbus_mem;

    localparam int          L     = 2;
    localparam int          DEPTH = 16384;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    sysbus_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    int tests = 0, fails = 0, cyc = 0;
    bit chk_en = 0;

    // Model state: one outstanding transaction and a sparse word memory with byte-known masks
    bit          out = 0, exp_err = 0, exp_known = 0, wr_pend = 0;
    int          acc = 0;
    logic [31:0] exp_rd = '0, wr_d = '0;
    logic [3:0]  wr_s = '0;
    int unsigned wr_idx = 0;
    logic [31:0] mdl [int unsigned];
    logic [3:0]  msk [int unsigned];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "bench stopped");
    endtask

    always @(posedge clk) begin
        longint unsigned a;
        logic [31:0]     w;
        logic [3:0]      m;
        if (rst) begin
            out     = 0;
            wr_pend = 0;
        end else if (out) begin
            if (resp_ready && cyc >= acc + L + 1) begin
                out = 0;
                if (wr_pend) begin
                    w = mdl.exists(wr_idx) ? mdl[wr_idx] : 32'h0;
                    m = msk.exists(wr_idx) ? msk[wr_idx] : 4'h0;
                    for (int b = 0; b < 4; b++)
                        if (wr_s[b]) begin
                            w[8*b +: 8] = wr_d[8*b +: 8];
                            m[b] = 1'b1;
                        end
                    mdl[wr_idx] = w;
                    msk[wr_idx] = m;
                end
                wr_pend = 0;
            end
        end else if (req_valid) begin
            a         = longint'(req_addr);
            out       = 1;
            acc       = cyc;
            exp_err   = (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
            exp_rd    = '0;
            exp_known = 1;
            wr_pend   = 0;
            if (!exp_err) begin
                wr_idx = int'((a - longint'(BASE)) / 4);
                if (req_we) begin
                    wr_pend = 1;
                    wr_d    = req_wdata;
                    wr_s    = req_wstrb;
                end else begin
                    exp_rd    = mdl.exists(wr_idx) ? mdl[wr_idx] : 32'h0;
                    exp_known = msk.exists(wr_idx) && msk[wr_idx] == 4'hF;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = out && (cyc >= acc + L + 1);
            chk("req_ready",  32'(req_ready),  32'(!out));
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            chk("resp_error", 32'(resp_error), ev ? 32'(exp_err) : 32'h0);
            if (!ev || exp_known) chk("resp_rdata", resp_rdata, ev ? exp_rd : 32'h0);
        end
    end

    // Called just after a rising edge; returns just after the handshake edge
    task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                        input logic [3:0] s, input int hold,
                        output logic [31:0] rd, output bit er, output int acc_c, output int rsp_c);
        int n;
        resp_ready = (hold == 0);
        req_valid = 1; req_addr = a; req_we = w; req_wdata = d; req_wstrb = s;
        n = 0;
        @(negedge clk);
        while (!req_ready) begin
            if (++n > 50) timeout("accept");
            @(negedge clk);
        end
        acc_c = cyc;
        @(posedge clk); #1;
        req_valid = 0; req_addr = $urandom; req_we = ~w; req_wdata = $urandom; req_wstrb = 4'hF;
        n = 0;
        @(negedge clk);
        while (!resp_valid) begin
            if (++n > 50) timeout("response");
            @(negedge clk);
        end
        rsp_c = cyc; rd = resp_rdata; er = resp_error;
        repeat (hold) begin
            @(posedge clk); #1;
            req_valid = 1; req_addr = BASE; req_we = 1; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
            @(negedge clk);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_req_ready", 32'(req_ready), 32'h0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            req_valid = 0;
            resp_ready = 1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        bit er;
        int ac, rc, prev_ac, n;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        @(posedge clk); #1;

        // first read: response lands three cycles after accept
        xfer(BASE, 0, 0, 4'h0, 0, rd, er, ac, rc);
        chk("first_latency", 32'(rc - ac), 32'd3);
        chk("first_error", 32'(er), 32'h0);

        // partial write merges strobed bytes
        xfer(BASE + 32'h10, 1, 32'h1122_3344, 4'hF, 0, rd, er, ac, rc);
        xfer(BASE + 32'h10, 1, 32'hDEAD_BEEF, 4'b0101, 0, rd, er, ac, rc);
        chk("write_rdata_zero", rd, 32'h0);
        xfer(BASE + 32'h10, 0, 0, 4'h0, 0, rd, er, ac, rc);
        chk("strobe_merge", rd, 32'h11AD_33EF);

        // range and alignment errors
        xfer(BASE + 32'h2, 0, 0, 4'h0, 0, rd, er, ac, rc);
        chk("misaligned_err", 32'(er), 32'h1);
        chk("misaligned_rdata", rd, 32'h0);
        xfer(32'h7FFF_FFFC, 0, 0, 4'h0, 0, rd, er, ac, rc);
        chk("below_base_err", 32'(er), 32'h1);
        xfer(BASE, 1, 32'hCAFE_F00D, 4'hF, 0, rd, er, ac, rc);
        xfer(32'h8001_0000, 1, 32'h5555_5555, 4'hF, 0, rd, er, ac, rc);
        chk("past_end_err", 32'(er), 32'h1);
        xfer(BASE, 0, 0, 4'h0, 0, rd, er, ac, rc);
        chk("past_end_no_alias", rd, 32'hCAFE_F00D);
        xfer(32'h8000_FFFC, 1, 32'h0F0F_0F0F, 4'hF, 0, rd, er, ac, rc);
        xfer(32'h8000_FFFC, 0, 0, 4'h0, 0, rd, er, ac, rc);
        chk("last_word_err", 32'(er), 32'h0);
        chk("last_word_data", rd, 32'h0F0F_0F0F);

        // zero-strobe write is a clean no-op
        xfer(BASE + 32'h10, 1, 32'h0, 4'h0, 0, rd, er, ac, rc);
        chk("nostrobe_err", 32'(er), 32'h0);

        // response held for several cycles while a new request is presented
        xfer(BASE + 32'h10, 0, 0, 4'h0, 5, rd, er, ac, rc);
        chk("held_data", rd, 32'h11AD_33EF);

        // reset on the cycle the write would be performed
        req_valid = 1; req_addr = BASE; req_we = 1; req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
        n = 0;
        @(negedge clk);
        while (!req_ready) begin
            if (++n > 50) timeout("reset_accept");
            @(negedge clk);
        end
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midreset_ready", 32'(req_ready), 32'h1);
        chk("midreset_valid", 32'(resp_valid), 32'h0);
        @(posedge clk); #1;
        xfer(BASE, 0, 0, 4'h0, 0, rd, er, ac, rc);
        chk("midreset_old_word", rd, 32'hCAFE_F00D);

        // back-to-back streaming
        for (int i = 0; i < 8; i++)
            xfer(BASE + 32'h100 + 32'(4 * i), 1, 32'hA500_0000 + 32'(i) * 32'h0001_0203, 4'hF, 0,
                 rd, er, ac, rc);
        prev_ac = -1;
        for (int i = 0; i < 8; i++) begin
            xfer(BASE + 32'h100 + 32'(4 * i), 0, 0, 4'h0, 0, rd, er, ac, rc);
            chk("b2b_data", rd, 32'hA500_0000 + 32'(i) * 32'h0001_0203);
            if (prev_ac >= 0) chk("b2b_interval", 32'(ac - prev_ac), 32'(L + 2));
            prev_ac = ac;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
